// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (idle high, start low, MSB-first
// data, one stop bit high). Each good byte is presented on dout together with
// a one-cycle valid strobe; a low stop bit raises a one-cycle frame_err.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   serial line, asynchronous to clk, idles high
//   dout      out  last correctly received byte
//   valid     out  one-cycle pulse, dout newly updated
//   frame_err out  one-cycle pulse, stop bit sampled low
//   busy      out  high while a frame is in START, DATA or STOP
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_busy;
  logic                 w_din_s;

  // Two-flop synchronizer; reset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], din};
    end
  end

  assign w_din_s = r_sync[1];

  // Receive FSM with registered strobes; busy is updated on the same edge as
  // the state so it tracks START/DATA/STOP exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_din_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Mid start bit: confirm the line is still low, else it was a glitch
          if (r_cnt == CNT_HALF) begin
            if (!w_din_s) begin
              r_state  <= S_DATA;
              r_cnt    <= '0;
              r_bitcnt <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          // Counter wraps naturally at OVERSAMPLE-1 (power of two)
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_shift  <= {r_shift[DATA_BITS-2:0], w_din_s};
            r_bitcnt <= r_bitcnt + BIT_W'(1);
            if (r_bitcnt == BIT_LAST) begin
              r_state <= S_STOP;
              r_cnt   <= '0;
            end
          end
        end
        S_STOP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_busy <= 1'b0;
            if (w_din_s) begin
              r_dout  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Held-low line: wait for release without re-arming start detection
          if (w_din_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = r_dout;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned OS = 16;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int last_valid_cyc = 0;
  int last_ferr_cyc = 0;
  int busy_hi_cnt = 0;
  int start_cyc = 0;
  bit prev_valid = 1'b0;
  bit prev_ferr = 1'b0;
  bit valid_long = 1'b0;
  bit ferr_long = 1'b0;
  bit both_hi = 1'b0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (prev_valid) valid_long = 1'b1;
    end
    if (frame_err) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
      if (prev_ferr) ferr_long = 1'b1;
    end
    if (valid && frame_err) both_hi = 1'b1;
    if (busy) busy_hi_cnt++;
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  // Called just after a rising edge; leaves the caller just after a rising edge
  task automatic send_bit(input bit v);
    din = v;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle_cycles(input int n);
    din = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    din   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 din = ~din;
    end
    n_vec++;
    if (dout !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got dout=%h valid=%b ferr=%b busy=%b required 00 0 0 0",
               dout, valid, frame_err, busy);
    end
    din = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    busy_hi_cnt = 0;
    idle_cycles(30);
    n_vec++;
    if (valid_cnt !== 0 || ferr_cnt !== 0 || busy_hi_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_release_idle: got valids=%0d ferrs=%0d busy_cycles=%0d required 0 0 0",
               valid_cnt, ferr_cnt, busy_hi_cnt);
    end
  endtask

  task automatic test_single;
    int v0;
    v0 = valid_cnt;
    busy_hi_cnt = 0;
    send_frame(8'hA5, 1'b1);
    n_vec++;
    if (dout !== 8'hA5) begin
      n_err++;
      $display("FAIL single_dout: got %h required a5", dout);
    end
    n_vec++;
    if (valid_cnt - v0 !== 1) begin
      n_err++;
      $display("FAIL single_valid_count: got %0d required 1", valid_cnt - v0);
    end
    n_vec++;
    if (last_valid_cyc - start_cyc !== 155) begin
      n_err++;
      $display("FAIL single_latency: got %0d required 155", last_valid_cyc - start_cyc);
    end
    n_vec++;
    if (busy_hi_cnt !== 152) begin
      n_err++;
      $display("FAIL single_busy_cycles: got %0d required 152", busy_hi_cnt);
    end
    idle_cycles(8);
  endtask

  task automatic test_glitch;
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_hi_cnt = 0;
    din = 1'b0;
    repeat (4) @(posedge clk);
    #1 din = 1'b1;
    idle_cycles(200);
    n_vec++;
    if (busy_hi_cnt !== 8) begin
      n_err++;
      $display("FAIL glitch_busy_cycles: got %0d required 8", busy_hi_cnt);
    end
    n_vec++;
    if (valid_cnt !== v0 || ferr_cnt !== f0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_no_strobe: got valids=%0d ferrs=%0d busy=%b required %0d %0d 0",
               valid_cnt, ferr_cnt, busy, v0, f0);
    end
    n_vec++;
    if (dout !== 8'hA5) begin
      n_err++;
      $display("FAIL glitch_dout_kept: got %h required a5", dout);
    end
  endtask

  task automatic test_framing;
    int v0;
    int f0;
    send_frame(8'h3C, 1'b1);
    idle_cycles(5);
    n_vec++;
    if (dout !== 8'h3C) begin
      n_err++;
      $display("FAIL framing_pre_dout: got %h required 3c", dout);
    end
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b0);
    din = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle_cycles(20);
    n_vec++;
    if (ferr_cnt - f0 !== 1) begin
      n_err++;
      $display("FAIL framing_err_count: got %0d required 1", ferr_cnt - f0);
    end
    n_vec++;
    if (last_ferr_cyc - start_cyc !== 155) begin
      n_err++;
      $display("FAIL framing_err_time: got %0d required 155", last_ferr_cyc - start_cyc);
    end
    n_vec++;
    if (valid_cnt !== v0 || dout !== 8'h3C) begin
      n_err++;
      $display("FAIL framing_no_valid: got valids=%0d dout=%h required %0d 3c", valid_cnt, dout, v0);
    end
    send_frame(8'h42, 1'b1);
    idle_cycles(5);
    n_vec++;
    if (dout !== 8'h42 || valid_cnt - v0 !== 1 || ferr_cnt - f0 !== 1) begin
      n_err++;
      $display("FAIL framing_recover: got dout=%h valids=%0d ferrs=%0d required 42 1 1",
               dout, valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    int t1;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    t1 = last_valid_cyc;
    n_vec++;
    if (dout !== 8'h00) begin
      n_err++;
      $display("FAIL b2b_first_dout: got %h required 00", dout);
    end
    send_frame(8'hFF, 1'b1);
    idle_cycles(5);
    n_vec++;
    if (dout !== 8'hFF) begin
      n_err++;
      $display("FAIL b2b_second_dout: got %h required ff", dout);
    end
    n_vec++;
    if (valid_cnt - v0 !== 2 || last_valid_cyc - t1 !== 160) begin
      n_err++;
      $display("FAIL b2b_spacing: got count=%0d gap=%0d required 2 160",
               valid_cnt - v0, last_valid_cyc - t1);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    // 0x5A = 0,1,0,1,1,0,1,0 MSB first; reset lands mid data bit 4
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    din = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dout !== 8'h00 || busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got dout=%h busy=%b valid=%b ferr=%b required 00 0 0 0",
               dout, busy, valid, frame_err);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(200);
    n_vec++;
    if (valid_cnt !== v0 || ferr_cnt !== f0 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_no_strobe: got valids=%0d ferrs=%0d dout=%h required %0d %0d 00",
               valid_cnt, ferr_cnt, dout, v0, f0);
    end
    send_frame(8'h5A, 1'b1);
    idle_cycles(5);
    n_vec++;
    if (dout !== 8'h5A || valid_cnt - v0 !== 1) begin
      n_err++;
      $display("FAIL midreset_recover: got dout=%h valids=%0d required 5a 1", dout, valid_cnt - v0);
    end
  endtask

  task automatic test_pulse_rules;
    n_vec++;
    if (valid_long !== 1'b0 || ferr_long !== 1'b0 || both_hi !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_rules: got valid_long=%b ferr_long=%b both=%b required 0 0 0",
               valid_long, ferr_long, both_hi);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b1;
    test_reset;
    test_single;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_mid_frame;
    test_pulse_rules;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
